// File: rtl/muldiv_if.sv
// muldiv_if: request/response bundle between the execute stage and muldiv_unit.
//   master (core side) drives start, flush, ALUOp, Funct7, Funct3, SrcA, SrcB.
//   slave  (unit side) drives is_mext, busy, done, Result.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             flush;
    logic [1:0]       ALUOp;
    logic [6:0]       Funct7;
    logic [2:0]       Funct3;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             is_mext;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;

    modport master (
        output start, flush, ALUOp, Funct7, Funct3, SrcA, SrcB,
        input  is_mext, busy, done, Result
    );

    modport slave (
        input  start, flush, ALUOp, Funct7, Funct3, SrcA, SrcB,
        output is_mext, busy, done, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
//   Decodes ALUOp=2'b10 / Funct7=7'b0000001 and runs MUL/MULH/MULHSU/MULHU
//   (shift-add) or DIV/DIVU/REM/REMU (restoring division), one bit per cycle
//   on operand magnitudes, with signs applied in a single fix-up cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    muldiv_if.slave: start/flush/ALUOp/Funct7/Funct3/SrcA/SrcB in,
//          is_mext (combinational), busy, done (1-cycle pulse), Result out
// Configuration:
//   MULDIV_EARLY_OUT_EN  when defined, divide-by-zero, signed overflow and
//                        zero-operand cases go IDLE -> FIX directly
//                        (done 2 cycles after start); otherwise every op
//                        takes exactly WIDTH+2 cycles.
//
// state | meaning
// IDLE  | waiting for an accepted start
// CALC  | WIDTH iterations of shift-add / restoring division
// FIX   | apply signs / special cases, register Result, pulse done
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic     clk,
    input logic     rst_n,
    muldiv_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef MULDIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi;        // product high half / partial remainder
    logic [WIDTH-1:0] lo;        // multiplier / dividend, becomes product low / quotient
    logic [WIDTH-1:0] addend;    // multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] a_raw;     // original SrcA, needed for div-by-zero / overflow results
    logic [2:0]       op;
    logic             sa, sb;
    logic             f_div0, f_ovf, f_zero;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q;

    assign bus.is_mext = (bus.ALUOp == 2'b10) && (bus.Funct7 == 7'b0000001);
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.Result  = result_q;

    // Operand classification at accept time.
    logic             in_div, in_sa, in_sb, in_div0, in_ovf, in_zero;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        in_div  = bus.Funct3[2];
        // signed A: MUL, MULH, MULHSU, DIV, REM; signed B: MUL, MULH, DIV, REM
        in_sa   = bus.SrcA[WIDTH-1] & (in_div ? ~bus.Funct3[0] : (bus.Funct3[1:0] != 2'b11));
        in_sb   = bus.SrcB[WIDTH-1] & (in_div ? ~bus.Funct3[0] : ~bus.Funct3[1]);
        a_mag   = in_sa ? -bus.SrcA : bus.SrcA;
        b_mag   = in_sb ? -bus.SrcB : bus.SrcB;
        in_div0 = in_div && (bus.SrcB == '0);
        in_ovf  = in_div && !bus.Funct3[0] && (bus.SrcA == MIN_NEG) && (bus.SrcB == '1);
        in_zero = (bus.SrcA == '0) || (bus.SrcB == '0);
    end

    // One iteration of each algorithm.
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rs;
    logic             ge;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, addend} : '0);
        rs   = {hi, lo[WIDTH-1]};
        ge   = rs >= {1'b0, addend};
        // When ge holds the true difference is below the divisor, so it fits WIDTH bits.
        diff = rs[WIDTH-1:0] - addend;
    end

    // Sign fix-up and special cases.
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo, rem, fix_res;

    always_comb begin
        prod_s = (sa ^ sb) ? -{hi, lo} : {hi, lo};
        quo    = (sa ^ sb) ? -lo : lo;
        rem    = sa ? -hi : hi;
        fix_res = '0;
        if (op[2]) begin
            if (f_div0)
                fix_res = op[1] ? a_raw : '1;
            else if (f_ovf)
                fix_res = op[1] ? '0 : a_raw;
            else
                fix_res = op[1] ? rem : quo;
        end else if (f_zero) begin
            // an early-out multiply never ran CALC, so hi/lo are not a product
            fix_res = '0;
        end else begin
            fix_res = (op[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            addend   <= '0;
            a_raw    <= '0;
            op       <= '0;
            sa       <= 1'b0;
            sb       <= 1'b0;
            f_div0   <= 1'b0;
            f_ovf    <= 1'b0;
            f_zero   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (bus.flush) begin
                state  <= IDLE;
                busy_q <= 1'b0;
                cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && bus.is_mext) begin
                            op     <= bus.Funct3;
                            sa     <= in_sa;
                            sb     <= in_sb;
                            a_raw  <= bus.SrcA;
                            f_div0 <= in_div0;
                            f_ovf  <= in_ovf;
                            f_zero <= in_zero;
                            hi     <= '0;
                            if (in_div) begin
                                addend <= b_mag;
                                lo     <= a_mag;
                            end else begin
                                addend <= a_mag;
                                lo     <= b_mag;
                            end
                            cnt    <= CNT_W'(WIDTH);
                            busy_q <= 1'b1;
                            if (EARLY_OUT && (in_div0 || in_ovf || in_zero))
                                state <= FIX;
                            else
                                state <= CALC;
                        end
                    end
                    CALC: begin
                        if (op[2]) begin
                            hi <= ge ? diff : rs[WIDTH-1:0];
                            lo <= {lo[WIDTH-2:0], ge};
                        end else begin
                            hi <= sum[WIDTH:1];
                            lo <= {sum[0], lo[WIDTH-1:1]};
                        end
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1))
                            state <= FIX;
                    end
                    FIX: begin
                        result_q <= fix_res;
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        cnt      <= '0;
                        state    <= IDLE;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
